// File: rtl/servo_frame_tx_ctrl.sv
// Bus-servo MOVE_TIME_WRITE frame sequencer feeding a UART byte transmitter.
// Define SERVO_CHECKSUM_EN to append the trailing checksum byte (10-byte frame instead of 9).
module servo_frame_tx_ctrl #(
    parameter logic [7:0]  CMD        = 8'd1,
    parameter logic [7:0]  LEN        = 8'd7,
    parameter logic [15:0] POS_MAX    = 16'd1000,
    parameter logic [15:0] TIME_MAX   = 16'd30000,
    parameter logic [15:0] TX_TIMEOUT = 16'd8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iStart,
    input  logic [7:0]  iId,
    input  logic [15:0] iPos,
    input  logic [15:0] iTime,
    output logic        oBusy,
    output logic        oDone,
    output logic        oErr,
    output logic        oTxCall,
    output logic [7:0]  oTxData,
    input  logic        iTxDone
);

    typedef enum logic [2:0] {IDLE, LOAD, CALL, GAP, DONE, ERR} state_t;

`ifdef SERVO_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_id;
    logic [15:0] r_pos, r_time;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        r_busy, r_done, r_err, r_tx_call;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_byte_nxt, w_csum;

    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [7:0] id,
                                              input logic [15:0] pos, input logic [15:0] tm,
                                              input logic [7:0] csum);
        logic [7:0] b;
        case (idx)
            4'd0, 4'd1: b = 8'h55;
            4'd2:       b = id;
            4'd3:       b = LEN;
            4'd4:       b = CMD;
            4'd5:       b = pos[7:0];
            4'd6:       b = pos[15:8];
            4'd7:       b = tm[7:0];
            4'd8:       b = tm[15:8];
            4'd9:       b = csum;
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef SERVO_CHECKSUM_EN
    logic [7:0] r_sum, w_sum_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = '0;
`ifdef SERVO_CHECKSUM_EN
        w_sum_nxt   = r_sum;
`endif
        case (r_state)
            IDLE: if (iStart) w_state_nxt = LOAD;
            LOAD: begin
                w_idx_nxt = '0;
`ifdef SERVO_CHECKSUM_EN
                w_sum_nxt = '0;
`endif
                w_state_nxt = CALL;
            end
            CALL: begin
                if (iTxDone) begin
                    w_state_nxt = GAP;
                end else if (r_cnt == TX_TIMEOUT - 16'd1) begin
                    w_state_nxt = ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            GAP: begin
                w_idx_nxt = r_idx + 4'd1;
`ifdef SERVO_CHECKSUM_EN
                // Only ID through time[15:8] contribute to the checksum.
                if (r_idx >= 4'd2 && r_idx <= 4'd8)
                    w_sum_nxt = r_sum + frame_byte(r_idx, r_id, r_pos, r_time, 8'h00);
`endif
                w_state_nxt = (r_idx == LAST_IDX) ? DONE : CALL;
            end
            DONE:    w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef SERVO_CHECKSUM_EN
    assign w_csum = ~w_sum_nxt;
`else
    assign w_csum = 8'h00;
`endif
    assign w_byte_nxt = frame_byte(w_idx_nxt, r_id, r_pos, r_time, w_csum);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_pos     <= '0;
            r_time    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tx_call <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= (w_state_nxt == DONE);
            r_err     <= (w_state_nxt == ERR);
            r_tx_call <= (w_state_nxt == CALL);
            r_tx_data <= (w_state_nxt == CALL) ? w_byte_nxt : 8'h00;
            if (r_state == IDLE && iStart) begin
                r_id   <= iId;
                r_pos  <= (iPos > POS_MAX) ? POS_MAX : iPos;
                r_time <= (iTime > TIME_MAX) ? TIME_MAX : iTime;
            end
        end
    end

`ifdef SERVO_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sum <= '0;
        else        r_sum <= w_sum_nxt;
    end
`endif

    assign oBusy   = r_busy;
    assign oDone   = r_done;
    assign oErr    = r_err;
    assign oTxCall = r_tx_call;
    assign oTxData = r_tx_data;

endmodule

// File: tb/tb_servo_frame_tx_ctrl.sv
// Directed bench for servo_frame_tx_ctrl with a small transmitter responder model.
// Frame length expectations follow SERVO_CHECKSUM_EN.
module tb_servo_frame_tx_ctrl;

`ifdef SERVO_CHECKSUM_EN
    localparam int NBYTES = 10;
`else
    localparam int NBYTES = 9;
`endif
    localparam int BYTE_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iStart = 1'b0;
    logic [7:0]  iId = 8'h00;
    logic [15:0] iPos = 16'h0000;
    logic [15:0] iTime = 16'h0000;
    logic        oBusy, oDone, oErr, oTxCall;
    logic [7:0]  oTxData;
    logic        model_done = 1'b0;
    logic        force_done = 1'b0;
    logic        w_tx_done;

    assign w_tx_done = model_done | force_done;

    servo_frame_tx_ctrl dut (
        .clk(clk), .rst_n(rst_n), .iStart(iStart), .iId(iId), .iPos(iPos), .iTime(iTime),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oTxCall(oTxCall), .oTxData(oTxData),
        .iTxDone(w_tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transmitter model: acknowledges each call after BYTE_CYC cycles and records the byte.
    bit         tx_en = 1'b1;
    logic [7:0] rx_q[$];
    int         stab_err = 0;
    int         m_cnt = 0;
    logic [7:0] m_first = 8'h00;

    always begin
        @(posedge clk); #1;
        if (model_done) begin
            model_done = 1'b0;
            m_cnt = 0;
        end else if (oTxCall) begin
            if (m_cnt == 0) m_first = oTxData;
            else if (oTxData !== m_first) stab_err++;
            m_cnt++;
            if (tx_en && m_cnt == BYTE_CYC) begin
                model_done = 1'b1;
                rx_q.push_back(m_first);
            end
        end else begin
            m_cnt = 0;
        end
    end

    logic [7:0] exp_basic [10] = '{8'h55, 8'h55, 8'h01, 8'h07, 8'h01, 8'hF4, 8'h01, 8'hE8, 8'h03, 8'h16};
    logic [7:0] exp_clamp [10] = '{8'h55, 8'h55, 8'h01, 8'h07, 8'h01, 8'hE8, 8'h03, 8'h30, 8'h75, 8'h66};

    logic       s_busy1, s_call1, s_call2;
    logic [7:0] s_data2;
    int  n_done, n_err, done_cyc, err_cyc, last_fall, rise_cyc;
    bit  timed_out;
    logic done_busy, busy_after, call_after;
    logic r_busy0, r_done0, r_err0, r_call0;
    logic [7:0] r_data0;

    task automatic start_frame(input logic [7:0] id, input logic [15:0] pos, input logic [15:0] tm);
        rx_q.delete();
        stab_err = 0;
        @(posedge clk); #1;
        iId = id; iPos = pos; iTime = tm; iStart = 1'b1;
        @(posedge clk); #1;
        iStart = 1'b0;
        iId = 8'hAA; iPos = 16'hFFFF; iTime = 16'h1234;
        s_busy1 = oBusy; s_call1 = oTxCall;
        @(posedge clk); #1;
        s_call2 = oTxCall; s_data2 = oTxData;
    endtask

    // action: 0 none, 1 second iStart, 2 reset pulse; applied once rx_q holds inject_at bytes.
    task automatic wait_end(input int budget, input int inject_at, input int action);
        int cyc;
        int tail;
        bit prev;
        bit injected;
        n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1; last_fall = -1;
        rise_cyc = s_call2 ? 0 : -1;
        timed_out = 1'b0; busy_after = 1'b1; call_after = 1'b1; done_busy = 1'b0;
        prev = s_call2; injected = 1'b0; cyc = 0; tail = -1;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (prev && !oTxCall) last_fall = cyc;
            if (!prev && oTxCall && rise_cyc < 0) rise_cyc = cyc;
            prev = oTxCall;
            if (tail >= 0 && cyc == tail - 2) begin
                busy_after = oBusy; call_after = oTxCall;
            end
            if (oDone) begin n_done++; done_cyc = cyc; done_busy = oBusy; end
            if (oErr) begin n_err++; err_cyc = cyc; end
            if ((n_done + n_err) > 0 && tail < 0) tail = cyc + 3;
            if (!injected && action != 0 && rx_q.size() == inject_at) begin
                injected = 1'b1;
                if (action == 1) begin
                    iId = 8'h02; iStart = 1'b1;
                    @(posedge clk); #1;
                    iStart = 1'b0;
                    cyc++;
                    prev = oTxCall;
                end else begin
                    rst_n = 1'b0;
                    #1;
                    r_busy0 = oBusy; r_done0 = oDone; r_err0 = oErr;
                    r_call0 = oTxCall; r_data0 = oTxData;
                    #2;
                    rst_n = 1'b1;
                    repeat (3) begin
                        @(posedge clk); #1;
                        if (oDone) n_done++;
                        if (oErr) n_err++;
                    end
                    break;
                end
            end
            if (tail >= 0 && cyc >= tail) break;
            if (cyc >= budget) begin timed_out = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", oBusy); end
        checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", oDone); end
        checks++; if (oErr !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", oErr); end
        checks++; if (oTxCall !== 1'b0) begin errors++; $display("FAIL reset_call got %b want 0", oTxCall); end
        checks++; if (oTxData !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", oTxData); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_txdone();
        @(posedge clk); #1;
        force_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force_done = 1'b0;
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL idle_txdone_busy got %b want 0", oBusy); end
        checks++; if (oTxCall !== 1'b0) begin errors++; $display("FAIL idle_txdone_call got %b want 0", oTxCall); end
    endtask

    task automatic test_basic_frame();
        start_frame(8'h01, 16'd500, 16'd1000);
        checks++; if (s_busy1 !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", s_busy1); end
        checks++; if (s_call1 !== 1'b0) begin errors++; $display("FAIL load_call got %b want 0", s_call1); end
        checks++; if (s_call2 !== 1'b1) begin errors++; $display("FAIL first_call got %b want 1", s_call2); end
        checks++; if (s_data2 !== 8'h55) begin errors++; $display("FAIL first_data got %h want 55", s_data2); end
        wait_end(400, 0, 0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", timed_out); end
        checks++; if (rx_q.size() !== NBYTES) begin errors++; $display("FAIL basic_len got %0d want %0d", rx_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_basic[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, rx_q[i], exp_basic[i]); end
        end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL basic_data_stable got %0d want 0", stab_err); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", n_done); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL basic_err_count got %0d want 0", n_err); end
        checks++; if (done_cyc - last_fall !== 1) begin errors++; $display("FAIL done_after_gap got %0d want 1", done_cyc - last_fall); end
        checks++; if (done_busy !== 1'b1) begin errors++; $display("FAIL busy_in_done got %b want 1", done_busy); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b want 0", busy_after); end
    endtask

    task automatic test_clamp();
        start_frame(8'h01, 16'd1200, 16'd40000);
        wait_end(400, 0, 0);
        checks++; if (rx_q.size() !== NBYTES) begin errors++; $display("FAIL clamp_len got %0d want %0d", rx_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_clamp[i]) begin errors++; $display("FAIL clamp_byte%0d got %h want %h", i, rx_q[i], exp_clamp[i]); end
        end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL clamp_done_count got %0d want 1", n_done); end
    endtask

    task automatic test_stall();
        tx_en = 1'b0;
        start_frame(8'h01, 16'd500, 16'd1000);
        wait_end(9000, 0, 0);
        tx_en = 1'b1;
        checks++; if (n_err !== 1) begin errors++; $display("FAIL stall_err_count got %0d want 1", n_err); end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL stall_done_count got %0d want 0", n_done); end
        checks++; if (err_cyc - rise_cyc !== 8000) begin errors++; $display("FAIL stall_latency got %0d want 8000", err_cyc - rise_cyc); end
        checks++; if (call_after !== 1'b0) begin errors++; $display("FAIL stall_call_after got %b want 0", call_after); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL stall_busy_after got %b want 0", busy_after); end
    endtask

    task automatic test_busy_ignore();
        int busy_seen;
        start_frame(8'h01, 16'd500, 16'd1000);
        wait_end(400, 3, 1);
        busy_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (oBusy) busy_seen++;
        end
        checks++; if (rx_q.size() !== NBYTES) begin errors++; $display("FAIL ignore_len got %0d want %0d", rx_q.size(), NBYTES); end
        checks++; if (rx_q.size() > 2 && rx_q[2] !== 8'h01) begin errors++; $display("FAIL ignore_id got %h want 01", rx_q[2]); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", n_done); end
        checks++; if (busy_seen !== 0) begin errors++; $display("FAIL ignore_queued got %0d busy cycles want 0", busy_seen); end
    endtask

    task automatic test_reset_mid_frame();
        start_frame(8'h01, 16'd500, 16'd1000);
        wait_end(400, 5, 2);
        checks++; if (r_busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", r_busy0); end
        checks++; if (r_done0 !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", r_done0); end
        checks++; if (r_err0 !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", r_err0); end
        checks++; if (r_call0 !== 1'b0) begin errors++; $display("FAIL midrst_call got %b want 0", r_call0); end
        checks++; if (r_data0 !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", r_data0); end
        checks++; if (n_done + n_err !== 0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", n_done + n_err); end
        start_frame(8'h01, 16'd500, 16'd1000);
        wait_end(400, 0, 0);
        checks++; if (rx_q.size() !== NBYTES) begin errors++; $display("FAIL postrst_len got %0d want %0d", rx_q.size(), NBYTES); end
        for (int i = 0; i < NBYTES && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_basic[i]) begin errors++; $display("FAIL postrst_byte%0d got %h want %h", i, rx_q[i], exp_basic[i]); end
        end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL postrst_done_count got %0d want 1", n_done); end
    endtask

    initial begin
        test_reset();
        test_idle_txdone();
        test_basic_frame();
        test_clamp();
        test_stall();
        test_busy_ignore();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_frame_tx_ctrl.md
# servo_frame_tx_ctrl

Upstream sequencer for the UART byte transmitter (115200 baud, `iCall`/`oDone` handshake). It latches one servo move command (ID, position, move time) and builds a bus-servo MOVE_TIME_WRITE frame. It then feeds the frame byte-by-byte into the transmitter and reports frame completion or a stalled transmitter. It sits between the gait/pose logic and the UART TX.

## Interface
- `CMD`, 8'd1, command byte placed in the frame.
- `LEN`, 8'd7, length byte placed in the frame.
- `POS_MAX`, 16'd1000, upper clamp for position.
- `TIME_MAX`, 16'd30000, upper clamp for move time.
- `TX_TIMEOUT`, 16'd8000, clk cycles allowed per byte before abort.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `iStart`  in  1  request; sampled only in IDLE.
- `iId`  in  8  servo ID.
- `iPos`  in  16  target position.
- `iTime`  in  16  move time, ms.
- `oBusy`  out  1  high from accepted start until DONE/ERR exits.
- `oDone`  out  1  one-cycle pulse, frame fully sent.
- `oErr`  out  1  one-cycle pulse, byte timeout abort.
- `oTxCall`  out  1  to transmitter `iCall`.
- `oTxData`  out  8  to transmitter `iData`.
- `iTxDone`  in  1  from transmitter `oDone`.

## Operation
- States: IDLE, LOAD, CALL, GAP, DONE, ERR.
- IDLE: `oTxCall`=0. On `iStart`=1, latch `iId`, the clamped `iPos` and the clamped `iTime`. Clamp rule: value > max → max. Go to LOAD.
- LOAD: byte index = 0, checksum accumulator = 0. Go to CALL.
- Frame order: 0x55, 0x55, ID, LEN, CMD, pos[7:0], pos[15:8], time[7:0], time[15:8], checksum.
- Checksum = bitwise NOT of the low 8 bits of the sum of bytes 2..8. The sum is accumulated as each byte is issued and stored 8-bit wrap-around.
- CALL: `oTxCall`=1. `oTxData` shows the current byte and is stable for the whole state. Timeout counter increments each cycle.
  - On `iTxDone`=1: drop `oTxCall` on the next cycle, clear the timeout counter, go to GAP.
  - If the counter reaches `TX_TIMEOUT`-1 with no `iTxDone`: go to ERR.
- GAP: `oTxCall`=0 for exactly one cycle; this lets the transmitter return to its load state.
  - Index +1.
  - If the index passes the last byte, go to DONE; otherwise go to CALL.
- DONE: `oDone`=1 for one cycle, then IDLE.
- ERR: `oErr`=1 for one cycle, `oTxCall`=0, then IDLE. A partial frame is not retried.
- `iStart` while `oBusy`=1 is ignored and not queued.
- `iTxDone` outside CALL is ignored.
- Input operands are used only at latch time; changes afterwards have no effect.

## Timing
- Reset values:
  - State IDLE.
  - `oBusy`=0, `oDone`=0, `oErr`=0, `oTxCall`=0, `oTxData`=8'h00.
  - Index, checksum and timeout counter all 0.
- `iStart` at edge N → `oBusy`=1 and LOAD at N+1 → `oTxCall`=1 with `oTxData`=0x55 at N+2.
- Per byte: CALL duration equals the transmitter's byte time (about 11×434 cycles), then 1 GAP cycle.
- `oDone` is asserted the cycle after the final GAP. `oBusy` falls in the same cycle that DONE/ERR exits to IDLE.
- Reset mid-frame: all outputs return to reset values immediately, whatever the state. No `oDone` or `oErr` is issued for the aborted frame.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SERVO_CHECKSUM_EN` defined:
  - The frame is 10 bytes, including the checksum byte.
  - The checksum accumulator is present.
- Not defined:
  - The frame is 9 bytes and ends after time[15:8].
  - No accumulator logic; DONE follows the GAP after byte 8.
  - All other behaviour is unchanged.

## Test plan
- Basic frame (macro defined): ID=0x01, pos=500, time=1000 → bytes 55 55 01 07 01 F4 01 E8 03 16, then `oDone` pulses once and `oBusy`=0.
- Clamp: pos=1200, time=40000 → position bytes E8 03, time bytes 30 75; checksum consistent with the clamped values.
- Stalled transmitter: `iTxDone` held 0 → `oErr` pulses exactly 8000 cycles after `oTxCall` rises; `oTxCall`=0 afterwards; no `oDone`.
- Busy ignore: second `iStart` with ID=0x02 issued during byte 3 → only one frame is sent, carrying ID 0x01.
- Reset mid-frame: `rst_n` pulsed low during byte 5 → all outputs return to reset values. A subsequent `iStart` produces a complete, correct frame starting from 0x55.
- Macro undefined: same stimulus as the basic frame → 9 bytes ending in 03, with `oDone` one cycle after the last GAP.
